// File: rtl/fifo_rd_pkg.sv
// ----------------------------------------------------------------------------
// fifo_rd_pkg
//   Shared types and constants for the FIFO read-side stream adapter.
//   - occ_e      : occupancy state of the 2-entry output buffer
//   - BUF_DEPTH  : number of output buffer entries
//   - occ_count  : occupancy state -> number of buffered words
// ----------------------------------------------------------------------------
package fifo_rd_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_ONE,
        ST_TWO
    } occ_e;

    localparam int BUF_DEPTH = 2;

    function automatic logic [1:0] occ_count(input occ_e occ);
        case (occ)
            ST_ONE:  return 2'd1;
            ST_TWO:  return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/fifo_stream_reader_if.sv
// ----------------------------------------------------------------------------
// fifo_stream_reader_if
//   Valid/ready stream carrying FIFO words downstream.
//   m_valid  : word on m_data is valid          (master -> slave)
//   m_data   : stream word                      (master -> slave)
//   m_ready  : sink accepts the word this cycle (slave  -> master)
// ----------------------------------------------------------------------------
interface fifo_stream_reader_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;

    modport master (output m_valid, output m_data, input m_ready);
    modport slave  (input m_valid, input m_data, output m_ready);
endinterface

// File: rtl/fifo_rd_skid2.sv
// ----------------------------------------------------------------------------
// fifo_rd_skid2
//   Two-entry head/tail register pair. The occupancy state is owned by the
//   parent; this block only moves data according to push/pop and that state.
//   clk, rst_n : clock, synchronous active-low reset (clears head only)
//   i_push     : write i_data at the tail position this cycle
//   i_pop      : head word is consumed this cycle
//   i_occ      : current occupancy state
//   i_data     : incoming word
//   o_head     : registered head entry
// ----------------------------------------------------------------------------
module fifo_rd_skid2
    import fifo_rd_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_push,
    input  logic                  i_pop,
    input  occ_e                  i_occ,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic [DATA_WIDTH-1:0] o_head
);

    logic [DATA_WIDTH-1:0] r_head;
    logic [DATA_WIDTH-1:0] r_tail;
    logic                  w_load_head;
    logic                  w_load_tail;
    logic                  w_shift;

    // Incoming word goes straight to the head when the buffer is empty, or
    // when the single buffered word leaves in the same cycle.
    assign w_load_head = i_push & ((i_occ == ST_EMPTY) | ((i_occ == ST_ONE) & i_pop));
    assign w_load_tail = i_push & (i_occ == ST_ONE) & ~i_pop;
    assign w_shift     = i_pop & (i_occ == ST_TWO);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_head <= '0;
        end else if (w_load_head) begin
            r_head <= i_data;
        end else if (w_shift) begin
            r_head <= r_tail;
        end
    end

    // NOTE: the tail is pure data storage qualified by the occupancy state,
    // so it is deliberately left without reset.
    always_ff @(posedge clk) begin
        if (w_load_tail) begin
            r_tail <= i_data;
        end
    end

    assign o_head = r_head;

endmodule

// File: rtl/fifo_stream_reader.sv
// ----------------------------------------------------------------------------
// fifo_stream_reader
//   Drains a standard-read FIFO (data one cycle after an accepted read) and
//   presents the words as a full-throughput valid/ready stream.
//   clk          : read-domain clock
//   rst_n        : synchronous active-low reset
//   fifo_empty   : registered FIFO empty flag
//   fifo_rd_data : FIFO read data, valid the cycle after fifo_rd_en
//   fifo_rd_en   : FIFO read request (combinational)
//   flush        : discard buffered and in-flight words
//   m            : stream master (m_valid / m_ready / m_data)
//   xfer_cnt     : wrapping count of accepted stream beats
// ----------------------------------------------------------------------------
module fifo_stream_reader
    import fifo_rd_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic                  fifo_rd_en,
    input  logic                  flush,
    fifo_stream_reader_if.master  m,
    output logic [CNT_WIDTH-1:0]  xfer_cnt
);

    occ_e                  r_occ;
    logic                  r_inflight;
    logic                  r_m_valid;
    logic [CNT_WIDTH-1:0]  r_xfer_cnt;

    logic                  w_pop;
    logic                  w_push;
    logic [2:0]            w_level;
    logic                  w_credit;
    logic                  w_rd_en;
    logic [DATA_WIDTH-1:0] w_head;

    assign w_pop  = r_m_valid & m.m_ready;
    // A word returning during a flush belongs to the discarded stream.
    assign w_push = r_inflight & ~flush;

    // Words we will own after this edge: buffered + returning - leaving.
    // Keeping this below the buffer depth before issuing a read is what
    // guarantees a returning word always finds a free entry.
    assign w_level  = {1'b0, occ_count(r_occ)} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_credit = (w_level < 3'(BUF_DEPTH));
    // rst_n gating keeps the read request low while the block is held in reset.
    assign w_rd_en  = rst_n & ~fifo_empty & ~flush & w_credit;

    assign fifo_rd_en = w_rd_en;

    // Occupancy FSM, in-flight flag and beat counter.
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_occ      <= ST_EMPTY;
            r_m_valid  <= 1'b0;
            r_inflight <= 1'b0;
            r_xfer_cnt <= '0;
        end else begin
            r_inflight <= w_rd_en;
            // A beat accepted in the flush cycle still happened downstream.
            if (w_pop) begin
                r_xfer_cnt <= r_xfer_cnt + CNT_WIDTH'(1);
            end
            if (flush) begin
                r_occ     <= ST_EMPTY;
                r_m_valid <= 1'b0;
            end else begin
                case (r_occ)
                    ST_EMPTY: begin
                        if (w_push) begin
                            r_occ     <= ST_ONE;
                            r_m_valid <= 1'b1;
                        end
                    end
                    ST_ONE: begin
                        if (w_push && !w_pop) begin
                            r_occ <= ST_TWO;
                        end else if (w_pop && !w_push) begin
                            r_occ     <= ST_EMPTY;
                            r_m_valid <= 1'b0;
                        end
                    end
                    ST_TWO: begin
                        if (w_pop) begin
                            r_occ <= ST_ONE;
                        end
                    end
                    default: begin
                        r_occ     <= ST_EMPTY;
                        r_m_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

    a_no_push_when_full: assert property (
        @(posedge clk) disable iff (!rst_n) !(w_push && (r_occ == ST_TWO))
    );

    fifo_rd_skid2 #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_push (w_push),
        .i_pop  (w_pop),
        .i_occ  (r_occ),
        .i_data (fifo_rd_data),
        .o_head (w_head)
    );

    assign m.m_valid = r_m_valid;
    assign m.m_data  = w_head;
    assign xfer_cnt  = r_xfer_cnt;

endmodule
